// File: rtl/cla_pipe_addsub_if.sv
// Operand/result handshake bundle for cla_pipe_addsub.
// The master drives operands and out_ready; the slave (the adder) returns in_ready and the result.
interface cla_pipe_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero
    );
endinterface

// File: rtl/cla_pipe_addsub.sv
// Two-stage pipelined carry-lookahead add/sub, WIDTH bits in GROUP-bit lookahead groups.
// Define CLA_SAT_EN to saturate s on signed overflow instead of wrapping.
module cla_pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input logic           clk,
    input logic           rst,
    cla_pipe_addsub_if.slave bus
);
    localparam int NG     = WIDTH / GROUP;
    localparam int STAGES = 2;

    generate
        if ((GROUP < 1) || (GROUP > WIDTH) || ((WIDTH % GROUP) != 0)) begin : g_bad_cfg
            $error("cla_pipe_addsub: WIDTH must be a positive multiple of GROUP");
        end
    endgenerate

    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [NG-1:0]    gp;
        logic [NG-1:0]    gg;
        logic             ci;
        logic             a_msb;
        logic             b_msb;
    } s1_t;

    logic [STAGES:1]  vld_pipe;
    logic             out_ld;
    logic             in_fire;
    logic [WIDTH-1:0] b_e;
    s1_t              s1_d;
    s1_t              s1_q;
    logic             t1;
    logic [NG:0]      cg;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] s_raw;
    logic [WIDTH-1:0] s_nxt;
    logic             t2;
    logic             ovf_nxt;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    // A stage may load when empty or when its occupant leaves this cycle.
    assign out_ld       = !vld_pipe[2] || bus.out_ready;
    assign bus.in_ready = !rst && (!vld_pipe[1] || out_ld);
    assign in_fire      = bus.in_valid && bus.in_ready;

    // Stage 1: per-bit p/g and per-group P/G as flat sums of products.
    always_comb begin
        b_e         = bus.b ^ {WIDTH{bus.sub}};
        s1_d        = '0;
        s1_d.p      = bus.a ^ b_e;
        s1_d.g      = bus.a & b_e;
        s1_d.ci     = bus.cin ^ bus.sub;
        s1_d.a_msb  = bus.a[WIDTH-1];
        s1_d.b_msb  = b_e[WIDTH-1];
        t1          = 1'b0;
        for (int k = 0; k < NG; k++) begin
            s1_d.gp[k] = &s1_d.p[k*GROUP +: GROUP];
            for (int i = 0; i < GROUP; i++) begin
                t1 = s1_d.g[k*GROUP+i];
                for (int m = i + 1; m < GROUP; m++) t1 = t1 & s1_d.p[k*GROUP+m];
                s1_d.gg[k] = s1_d.gg[k] | t1;
            end
        end
    end

    // Stage 2: group carries from P/G, then bit carries seeded by each group's carry-in.
    always_comb begin
        cg = '0;
        c  = '0;
        t2 = 1'b0;
        for (int k = 0; k <= NG; k++) begin
            t2 = s1_q.ci;
            for (int j = 0; j < k; j++) t2 = t2 & s1_q.gp[j];
            cg[k] = t2;
            for (int j = 0; j < k; j++) begin
                t2 = s1_q.gg[j];
                for (int m = j + 1; m < k; m++) t2 = t2 & s1_q.gp[m];
                cg[k] = cg[k] | t2;
            end
        end
        for (int k = 0; k < NG; k++) begin
            for (int i = 0; i < GROUP; i++) begin
                t2 = cg[k];
                for (int j = 0; j < i; j++) t2 = t2 & s1_q.p[k*GROUP+j];
                c[k*GROUP+i] = t2;
                for (int j = 0; j < i; j++) begin
                    t2 = s1_q.g[k*GROUP+j];
                    for (int m = j + 1; m < i; m++) t2 = t2 & s1_q.p[k*GROUP+m];
                    c[k*GROUP+i] = c[k*GROUP+i] | t2;
                end
            end
        end
        s_raw   = s1_q.p ^ c;
        ovf_nxt = (s1_q.a_msb == s1_q.b_msb) && (s_raw[WIDTH-1] != s1_q.a_msb);
`ifdef CLA_SAT_EN
        // On overflow the true result has the sign of a.
        s_nxt = ovf_nxt ? (s1_q.a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                        : s_raw;
`else
        s_nxt = s_raw;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s_q      <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            if (in_fire) s1_q <= s1_d;
            vld_pipe[1] <= in_fire || (vld_pipe[1] && !out_ld);
            if (out_ld) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    s_q    <= s_nxt;
                    cout_q <= cg[NG];
                    ovf_q  <= ovf_nxt;
                    zero_q <= (s_nxt == '0);
                end
            end
        end
    end

    assign bus.out_valid = vld_pipe[2];
    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule
